// File: rtl/param_proc_controller.sv
// param_proc_controller: multi-cycle datapath sequencer.
// Accepts an instruction word in IDLE, then steps DECODE -> (EXEC -> WB),
// driving register-file, accumulator and bus control strobes for each step.
// Optional build macro: PCTRL_STALL_EN adds a 'stall' input that freezes
// the sequencer and suppresses its side-effecting strobes.
`timescale 1ns/1ps

module param_proc_controller #(
  parameter  int DATA_W = 10,
  parameter  int NREG   = 4,
  localparam int RA_W   = (NREG > 2) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef PCTRL_STALL_EN
  input  logic              stall,
`endif
  input  logic [DATA_W-1:0] instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [RA_W-1:0]   rin,
  output logic [RA_W-1:0]   rout,
  output logic              enw,
  output logic              enr,
  output logic              ain,
  output logic              gin,
  output logic              gout,
  output logic              ext,
  output logic              ir_in,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] imm,
  output logic              done,
  output logic              illegal,
  output logic              busy
);

  localparam int IMM_LO = 4 + RA_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    OP_LOAD = 4'd0,  OP_COPY = 4'd1,  OP_ADD  = 4'd2,  OP_SUB  = 4'd3,
    OP_COMP = 4'd4,  OP_FLIP = 4'd5,  OP_AND  = 4'd6,  OP_OR   = 4'd7,
    OP_XOR  = 4'd8,  OP_SFTL = 4'd9,  OP_SFTR = 4'd10, OP_ARSR = 4'd11,
    OP_AIMM = 4'd12, OP_SIMM = 4'd13
  } op_e;

  state_e            state;
  logic [DATA_W-1:0] ir;
  logic              run;

  logic [3:0]        opc;
  logic [RA_W-1:0]   rx;
  logic [RA_W-1:0]   ry;
  logic [DATA_W-1:0] imm_ext;
  logic              op_illegal;
  logic              op_single;
  logic              op_binary;
  logic              op_immed;
  logic              op_unary;

`ifdef PCTRL_STALL_EN
  assign run = ~stall;
`else
  assign run = 1'b1;
`endif

  // Instruction field decode from the held IR
  assign opc        = ir[3:0];
  assign rx         = ir[4 +: RA_W];
  assign ry         = ir[4+RA_W +: RA_W];
  assign imm_ext    = ir >> IMM_LO;
  assign op_illegal = (opc > OP_SIMM);
  assign op_single  = (opc == OP_LOAD) || (opc == OP_COPY);
  assign op_unary   = (opc == OP_COMP) || (opc == OP_FLIP);
  assign op_immed   = (opc == OP_AIMM) || (opc == OP_SIMM);
  assign op_binary  = !op_illegal && !op_single && !op_unary && !op_immed;

  // Sequencer state and instruction register; frozen while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ir    <= '0;
    end else if (run) begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= S_DECODE;
          end
        end
        S_DECODE: state <= (op_single || op_illegal) ? S_IDLE : S_EXEC;
        S_EXEC:   state <= S_WB;
        S_WB:     state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Per-step control strobes; stall masks the side-effecting ones afterwards
  always_comb begin
    instr_ready = 1'b0;
    rin         = '0;
    rout        = '0;
    enw         = 1'b0;
    enr         = 1'b0;
    ain         = 1'b0;
    gin         = 1'b0;
    gout        = 1'b0;
    ext         = 1'b0;
    ir_in       = 1'b0;
    alu_op      = '0;
    imm         = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        instr_ready = run;
        // rst_n gating keeps the bus strobes quiet while reset is held
        if (run && instr_valid && rst_n) begin
          ext   = 1'b1;
          ir_in = 1'b1;
        end
      end
      S_DECODE: begin
        if (opc == OP_LOAD) begin
          ext  = 1'b1;
          enw  = 1'b1;
          rin  = rx;
          done = 1'b1;
        end else if (opc == OP_COPY) begin
          enr  = 1'b1;
          rout = ry;
          enw  = 1'b1;
          rin  = rx;
          done = 1'b1;
        end else if (op_illegal) begin
          illegal = 1'b1;
        end else begin
          enr  = 1'b1;
          ain  = 1'b1;
          rout = op_unary ? ry : rx;
        end
      end
      S_EXEC: begin
        gin    = 1'b1;
        alu_op = opc;
        if (op_binary) begin
          enr  = 1'b1;
          rout = ry;
        end
        if (op_immed) imm = imm_ext;
      end
      S_WB: begin
        gout = 1'b1;
        enw  = 1'b1;
        rin  = rx;
        done = 1'b1;
      end
      default: ;
    endcase
    if (!run) begin
      enw     = 1'b0;
      ain     = 1'b0;
      gin     = 1'b0;
      ir_in   = 1'b0;
      done    = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_param_proc_controller.sv
// Bench for param_proc_controller (default DATA_W=10, NREG=4).
// Expected per-cycle outputs are built from the instruction's opcode class.
`timescale 1ns/1ps

module tb_param_proc_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] instr = '0;
  logic       instr_valid = 1'b0;
`ifdef PCTRL_STALL_EN
  logic       stall = 1'b0;
`endif
  logic       instr_ready, enw, enr, ain, gin, gout, ext, ir_in, done, illegal, busy;
  logic [1:0] rin, rout;
  logic [3:0] alu_op;
  logic [9:0] imm;

  always #5 clk = ~clk;

  param_proc_controller #(.DATA_W(10), .NREG(4)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef PCTRL_STALL_EN
    .stall(stall),
`endif
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .rin(rin), .rout(rout), .enw(enw), .enr(enr), .ain(ain), .gin(gin),
    .gout(gout), .ext(ext), .ir_in(ir_in), .alu_op(alu_op), .imm(imm),
    .done(done), .illegal(illegal), .busy(busy)
  );

  typedef struct packed {
    logic       ready;
    logic [1:0] rin;
    logic [1:0] rout;
    logic       enw, enr, ain, gin, gout, ext, ir_in;
    logic [3:0] alu_op;
    logic [9:0] imm;
    logic       done, illegal, busy;
  } outs_t;

  outs_t got;
  always_comb got = '{ready: instr_ready, rin: rin, rout: rout, enw: enw, enr: enr,
                      ain: ain, gin: gin, gout: gout, ext: ext, ir_in: ir_in,
                      alu_op: alu_op, imm: imm, done: done, illegal: illegal, busy: busy};

  int    checks = 0;
  int    errors = 0;
  outs_t expq[$];

  typedef struct {
    logic [9:0] ins;
    int         lat;
  } vec_t;

  function automatic outs_t idle_o();
    outs_t o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  task automatic check(input string name, input outs_t g, input outs_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, g, e);
    end
  endtask

  task automatic check_bit(input string name, input logic g, input logic e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, g, e);
    end
  endtask

  // Expected cycle-by-cycle outputs for one instruction, from the accept cycle on
  task automatic build_exp(input logic [9:0] ins);
    logic [3:0] op   = ins[3:0];
    logic [1:0] rx   = ins[5:4];
    logic [1:0] ry   = ins[7:6];
    logic [9:0] immv = {6'b0, ins[9:6]};
    outs_t o;
    expq.delete();
    o = idle_o(); o.ext = 1'b1; o.ir_in = 1'b1;
    expq.push_back(o);
    o = '0; o.busy = 1'b1;
    if (op == 4'd0) begin
      o.ext = 1'b1; o.enw = 1'b1; o.rin = rx; o.done = 1'b1;
      expq.push_back(o);
    end else if (op == 4'd1) begin
      o.enr = 1'b1; o.rout = ry; o.enw = 1'b1; o.rin = rx; o.done = 1'b1;
      expq.push_back(o);
    end else if (op >= 4'd14) begin
      o.illegal = 1'b1;
      expq.push_back(o);
    end else begin
      o.enr = 1'b1; o.ain = 1'b1; o.rout = (op == 4'd4 || op == 4'd5) ? ry : rx;
      expq.push_back(o);
      o = '0; o.busy = 1'b1; o.gin = 1'b1; o.alu_op = op;
      if (op inside {4'd2, 4'd3, [4'd6:4'd11]}) begin
        o.enr = 1'b1; o.rout = ry;
      end
      if (op >= 4'd12) o.imm = immv;
      expq.push_back(o);
      o = '0; o.busy = 1'b1; o.gout = 1'b1; o.enw = 1'b1; o.rin = rx; o.done = 1'b1;
      expq.push_back(o);
    end
  endtask

  // Called at posedge+1 with the controller idle; returns at posedge+1 idle again
  task automatic run_instr(input logic [9:0] ins, input int exp_lat, input string tag);
    int fin_at = -1;
    build_exp(ins);
    foreach (expq[i]) begin
      if (i == 0) begin
        instr = ins; instr_valid = 1'b1;
      end else begin
        instr = 10'($urandom); instr_valid = 1'($urandom);
      end
      #3;
      check($sformatf("%s_ins%h_c%0d", tag, ins, i), got, expq[i]);
      if (got.done || got.illegal) fin_at = i;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    checks++;
    if (fin_at != exp_lat) begin
      errors++;
      $display("FAIL %s_latency ins=%h got=%0d exp=%0d", tag, ins, fin_at, exp_lat);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      instr_valid = 1'b0; instr = 10'($urandom);
      #3;
      check("idle", got, idle_o());
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[10];
    vt[0] = '{ins: {4'b0000, 2'b10, 4'd0},  lat: 1};  // LOAD RX=2
    vt[1] = '{ins: {2'b00, 2'b11, 2'b01, 4'd2}, lat: 3};  // ADD RX=1 RY=3
    vt[2] = '{ins: {4'b1010, 2'b00, 4'd12}, lat: 3};  // AIMM RX=0 imm=10
    vt[3] = '{ins: {6'b000000, 4'd15}, lat: 1};       // illegal 15
    vt[4] = '{ins: {2'b00, 2'b10, 2'b11, 4'd1}, lat: 1};  // COPY RX=3 RY=2
    vt[5] = '{ins: {2'b00, 2'b01, 2'b10, 4'd4}, lat: 3};  // COMP RX=2 RY=1
    vt[6] = '{ins: {2'b11, 2'b11, 2'b00, 4'd5}, lat: 3};  // FLIP
    vt[7] = '{ins: {4'b1111, 2'b11, 4'd13}, lat: 3};  // SIMM imm=15
    vt[8] = '{ins: {2'b01, 2'b10, 2'b01, 4'd11}, lat: 3}; // ARSR
    vt[9] = '{ins: {6'b101010, 4'd14}, lat: 1};       // illegal 14

    // Reset holds outputs quiet even with a valid instruction offered
    instr = vt[0].ins; instr_valid = 1'b1;
    #2;
    check("reset_state", got, idle_o());
    @(posedge clk); #1;
    check("reset_after_edge", got, idle_o());
    rst_n = 1'b1;
    // First acceptance on the first rising edge with reset released
    run_instr(vt[0].ins, vt[0].lat, "first");

    for (int i = 0; i < 10; i++) begin
      run_instr(vt[i].ins, vt[i].lat, $sformatf("vec%0d", i));
      idle_cycles(1);
    end

    // Reset asserted during EXEC of SUB: immediate return to idle, no done
    instr = {2'b00, 2'b01, 2'b10, 4'd3}; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    #1;
    check_bit("sub_in_exec_gin", got.gin, 1'b1);
    rst_n = 1'b0; instr_valid = 1'b1;
    #1;
    check("rst_mid_async", got, idle_o());
    @(posedge clk); #1;
    check("rst_mid_held", got, idle_o());
    @(negedge clk);
    rst_n = 1'b1; instr_valid = 1'b0;
    @(posedge clk); #1;
    run_instr({2'b00, 2'b01, 2'b10, 4'd3}, 3, "after_rst");

`ifdef PCTRL_STALL_EN
    begin
      int cyc = 0;
      instr = {2'b00, 2'b00, 2'b11, 4'd8}; instr_valid = 1'b1;
      #3; check_bit("stall_accept_irin", got.ir_in, 1'b1);
      @(posedge clk); #1; cyc++;
      instr_valid = 1'b0;
      #3; check_bit("stall_decode_ain", got.ain, 1'b1);
      @(posedge clk); #1; cyc++;
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
        #3;
        check_bit("stall_gin", got.gin, 1'b0);
        check_bit("stall_done", got.done, 1'b0);
        check_bit("stall_ready", got.ready, 1'b0);
        @(posedge clk); #1; cyc++;
      end
      stall = 1'b0;
      #3; check_bit("stall_exec_gin", got.gin, 1'b1);
      @(posedge clk); #1; cyc++;
      #3;
      check_bit("stall_wb_done", got.done, 1'b1);
      check_bit("stall_wb_enw", got.enw, 1'b1);
      checks++;
      if (got.rin !== 2'd3 || cyc != 6) begin
        errors++;
        $display("FAIL stall_wb rin=%0d cyc=%0d exp rin=3 cyc=6", got.rin, cyc);
      end
      @(posedge clk); #1;
      idle_cycles(1);
    end
`endif

    // Randomized instruction stream with random idle gaps
    for (int n = 0; n < 150; n++) begin
      logic [9:0] r;
      r = 10'($urandom);
      idle_cycles(int'($urandom_range(0, 2)));
      run_instr(r, (r[3:0] < 4'd2 || r[3:0] >= 4'd14) ? 1 : 3, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_proc_controller.md
PARAM_PROC_CONTROLLER -- requirements
Module: param_proc_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 10, meaning instruction and immediate width (minimum 10).
REQ-002 SHALL have parameter NREG, default 4, meaning register file depth; RA_W = clog2(NREG), minimum 1.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port instr, input, DATA_W, meaning the instruction word offered by the external source.
REQ-006 SHALL have port instr_valid, input, 1, meaning instr is valid this cycle.
REQ-007 SHALL have port instr_ready, output, 1, meaning the controller accepts instr this cycle.
REQ-008 SHALL have ports rin and rout, output, RA_W each, meaning the register-file write address and read address.
REQ-009 SHALL have ports enw, enr, ain, gin, gout, ext and ir_in, output, 1 each, meaning: write enable, read enable, load A, load G, drive G onto the bus, drive external data onto the bus, and load the instruction register.
REQ-010 SHALL have port alu_op, output, 4, meaning the ALU operation code.
REQ-011 SHALL have port imm, output, DATA_W, meaning the immediate operand; it is zero outside the EXEC step of AIMM/SIMM.
REQ-012 SHALL have ports done, illegal and busy, output, 1 each, meaning: instruction complete, undefined opcode, and not IDLE.

Function
REQ-013 Instruction fields SHALL be: opcode = instr[3:0], RX = instr[4 +: RA_W], RY = instr[4+RA_W +: RA_W], and imm = instr[DATA_W-1 : 4+RA_W] zero-extended.
REQ-014 Opcodes SHALL be: LOAD=0, COPY=1, ADD=2, SUB=3, COMP=4, FLIP=5, AND=6, OR=7, XOR=8, SFTL=9, SFTR=10, ARSR=11, AIMM=12, SIMM=13; opcodes 14 and 15 are illegal.
REQ-015 The FSM SHALL have the states IDLE, DECODE, EXEC and WB; busy = (state != IDLE).
REQ-016 In IDLE: instr_ready=1; when instr_valid is also 1, assert ext=1 and ir_in=1 combinationally, capture instr into the internal IR, and go to DECODE.
REQ-017 In any state other than IDLE, instr_ready=0 and instr_valid SHALL be ignored; the IR SHALL hold its value.
REQ-018 DECODE for LOAD SHALL assert ext=1, enw=1, rin=RX and done=1, then go to IDLE.
REQ-019 DECODE for COPY SHALL assert enr=1, rout=RY, enw=1, rin=RX and done=1, then go to IDLE.
REQ-020 DECODE for COMP/FLIP SHALL assert enr=1, rout=RY, ain=1; for every other ALU opcode it SHALL assert enr=1, rout=RX, ain=1; then go to EXEC.
REQ-021 DECODE for an illegal opcode SHALL assert illegal=1 for one cycle with all enables 0 and done=0, then go to IDLE.
REQ-022 EXEC SHALL assert gin=1 and alu_op=opcode; binary ops (2,3,6-11) add enr=1, rout=RY; AIMM/SIMM drive imm; then go to WB.
REQ-023 WB SHALL assert gout=1, enw=1, rin=RX and done=1, then go to IDLE.
REQ-024 Latency from the accept edge to done: 1 cycle for LOAD/COPY, 3 cycles for ALU ops; throughput SHALL be one instruction per 2 or 4 cycles.
REQ-025 Every output not explicitly asserted in a step SHALL be 0; done and illegal SHALL be single-cycle pulses.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE and IR=0; outputs SHALL be instr_ready=1 and all others 0, including mid-instruction, with no done pulse.
REQ-027 The first acceptance SHALL be on the first rising edge with rst_n=1.

Configuration
REQ-028 With macro PCTRL_STALL_EN defined: an input port stall (1 bit) SHALL exist. While stall=1, the state and IR SHALL freeze; enw, ain, gin, ir_in, done and illegal SHALL be forced to 0; and instr_ready SHALL be 0. On release, the same step SHALL re-execute.
REQ-029 Without PCTRL_STALL_EN: no stall port, and the FSM never stalls.

Verification
REQ-030 Reset, then instr=LOAD with RX=2 and valid=1 -> accept cycle ext=ir_in=1; next cycle ext=enw=done=1, rin=2; then IDLE.
REQ-031 ADD with RX=1, RY=3 -> DECODE: rout=1, ain=1; EXEC: rout=3, gin=1, alu_op=2; WB: rin=1, gout=enw=done=1.
REQ-032 AIMM with RX=0 and immediate field 4'b1010 -> EXEC imm=10'd10, alu_op=12; imm=0 in all other cycles.
REQ-033 Opcode 15 -> illegal pulses in DECODE, no enable asserted, done=0, instr_ready=1 on the next cycle.
REQ-034 rst_n pulled low in EXEC of SUB -> outputs go to reset values without a clock edge; no done; the next instruction proceeds normally.
REQ-035 With PCTRL_STALL_EN: stall=1 for 3 cycles during EXEC of XOR -> gin stays 0 while stalled; done arrives 3 cycles late; register writes are unchanged.
